// File: rtl/vga_buf_scan.sv
// VGA 640x480 timing generator that scans the 320x240 frame buffer with a pipelined read.
// Owns the ping-pong bank select so the display never shows a half-written frame.
module vga_buf_scan #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [16:0] vga_out_addr,
  input  logic [11:0] pixel_in,
  input  logic        frame_ready,
  output logic        buf_sel,
  output logic        swap_done,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [11:0] rgb
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic hs;
    logic vs;
    logic bl;
  } tmg_t;

  localparam tmg_t TMG_IDLE = '{hs: 1'b1, vs: 1'b1, bl: 1'b1};

  logic [HW-1:0]         hcount;
  logic [VW-1:0]         vcount;
  logic                  active;
  logic                  swap_point;
  logic                  swap_pending;
  logic [16:0]           row;
  logic [16:0]           addr_next;
  tmg_t                  tmg_now;
  tmg_t [READ_LAT:0]     tmg_pipe;

  always_comb begin
    active     = (hcount < H_ACT) && (vcount < V_ACT);
    tmg_now.hs = ~((hcount >= HS_BEG) && (hcount < HS_END));
    tmg_now.vs = ~((vcount >= VS_BEG) && (vcount < VS_END));
    tmg_now.bl = ~active;
    // Buffer row stride is 320 words: row*256 + row*64.
    row        = 17'(vcount >> 1);
    addr_next  = (row << 8) + (row << 6) + 17'(hcount >> 1);
    swap_point = (hcount == '0) && (vcount == V_ACT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vga_out_addr <= '0;
    else       vga_out_addr <= active ? addr_next : '0;
  end

  // Stage READ_LAT-1 lines up with pixel_in; stage READ_LAT lines up with rgb.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= READ_LAT; i++) tmg_pipe[i] <= TMG_IDLE;
    end else begin
      tmg_pipe <= {tmg_pipe[READ_LAT-1:0], tmg_now};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb <= '0;
    else       rgb <= tmg_pipe[READ_LAT-1].bl ? 12'h000 : pixel_in;
  end

  assign hsync = tmg_pipe[READ_LAT].hs;
  assign vsync = tmg_pipe[READ_LAT].vs;
  assign blank = tmg_pipe[READ_LAT].bl;

  // Swap only on the first blank line so the display bank is stable through active video.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_sel      <= 1'b0;
      swap_done    <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      if (swap_point && (swap_pending || frame_ready)) begin
        buf_sel      <= ~buf_sel;
        swap_done    <= 1'b1;
        swap_pending <= 1'b0;
      end else if (frame_ready) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_buf_scan.sv
// Self-checking bench for vga_buf_scan on a shrunken raster, compared cycle by cycle
// against a raster model derived from the raw cycle index since reset.
module tb_vga_buf_scan;
  localparam int HA = 64, HF = 6, HS = 10, HB = 8;
  localparam int VA = 40, VF = 3, VS = 2, VB = 4;
  localparam int RL = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int SP = VA * HT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] vga_out_addr;
  logic [11:0] pixel_in = '0;
  logic        frame_ready = 1'b0;
  logic        buf_sel, swap_done, hsync, vsync, blank;
  logic [11:0] rgb;

  vga_buf_scan #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .READ_LAT(RL)
  ) dut (
    .clk(clk), .reset(reset), .vga_out_addr(vga_out_addr), .pixel_in(pixel_in),
    .frame_ready(frame_ready), .buf_sel(buf_sel), .swap_done(swap_done),
    .hsync(hsync), .vsync(vsync), .blank(blank), .rgb(rgb)
  );

  always #5 clk = ~clk;

  int          errors = 0, checks = 0;
  int          edges = 0;
  logic        fr_last = 1'b0;
  int          mode = 0;
  logic [11:0] rtab [76800];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  function automatic bit is_active(int h, int v);
    return (h < HA) && (v < VA);
  endfunction

  function automatic logic [16:0] addr_of(int r);
    int h, v;
    h = r % HT;
    v = (r / HT) % VT;
    return is_active(h, v) ? 17'((v / 2) * 320 + h / 2) : 17'd0;
  endfunction

  function automatic logic [11:0] mem_f(logic [16:0] a);
    case (mode)
      0:       return a[11:0];
      1:       return 12'hFFF;
      default: return rtab[a];
    endcase
  endfunction

  // Synchronous RAM: data follows the registered address by one more clock.
  always @(posedge clk) pixel_in <= mem_f(vga_out_addr);

  always @(posedge clk) begin
    if (reset) edges = 0;
    else begin
      fr_last = frame_ready;
      edges   = edges + 1;
    end
  end

  logic exp_sel = 1'b0, exp_pend = 1'b0, exp_done = 1'b0;
  int   r, ro, oh, ov, nswap = 0;
  int   hrun = 0, vrun = 0, hs_tot = 0, vs_tot = 0, bl_tot = 0;
  logic e_hs, e_vs, e_bl;
  logic [11:0] e_rgb;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_addr", vga_out_addr, 0);
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_blank", blank, 1);
      chk("rst_rgb", rgb, 0);
      chk("rst_buf_sel", buf_sel, 0);
      chk("rst_swap_done", swap_done, 0);
      exp_sel = 1'b0; exp_pend = 1'b0; exp_done = 1'b0;
      hrun = 0; vrun = 0;
    end else if (edges > 0) begin
      r = edges - 1;
      exp_done = 1'b0;
      if (fr_last) exp_pend = 1'b1;
      if ((r % FR) == SP && exp_pend) begin
        exp_sel  = ~exp_sel;
        exp_done = 1'b1;
        exp_pend = 1'b0;
      end
      chk("addr", vga_out_addr, addr_of(r));
      chk("buf_sel", buf_sel, exp_sel);
      chk("swap_done", swap_done, exp_done);
      if (swap_done === 1'b1) nswap++;

      if (r == 5 * HT + 3)             chk("addr_3_5", vga_out_addr, 641);
      if (r == (VA - 1) * HT + HA - 1) chk("addr_last", vga_out_addr, (VA / 2 - 1) * 320 + HA / 2 - 1);
      if (r == HA)                     chk("addr_blank", vga_out_addr, 0);

      if (r >= RL) begin
        ro = r - RL;
        oh = ro % HT;
        ov = (ro / HT) % VT;
        e_hs  = !(oh >= HA + HF && oh < HA + HF + HS);
        e_vs  = !(ov >= VA + VF && ov < VA + VF + VS);
        e_bl  = !is_active(oh, ov);
        e_rgb = e_bl ? 12'h000 : mem_f(addr_of(ro));
        if (ro == 5 * HT + 3 && mode == 0) chk("rgb_3_5", rgb, 12'h281);
        if (ro == 0)                       chk("first_unblank", blank, 0);
      end else begin
        ro = -1;
        e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b1; e_rgb = 12'h000;
      end
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("blank", blank, e_bl);
      chk("rgb", rgb, e_rgb);

      if (hsync === 1'b0) hrun++;
      else if (hrun > 0) begin
        chk("hsync_width", hrun, HS);
        hrun = 0;
      end
      if (vsync === 1'b0) vrun++;
      else if (vrun > 0) begin
        chk("vsync_width", vrun, VS * HT);
        vrun = 0;
      end
      if (ro >= FR && ro < 2 * FR) begin
        if (hsync === 1'b0) hs_tot++;
        if (vsync === 1'b0) vs_tot++;
        if (blank === 1'b1) bl_tot++;
      end
    end
  end

  task automatic wait_edges(input int t);
    int guard;
    guard = 0;
    while (edges != t && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    if (edges != t) chk("wait_timeout", edges, t);
  endtask

  task automatic pulse_at(input int t);
    wait_edges(t);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 76800; i++) rtab[i] = 12'($urandom);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    // Mid-line reset, held for five clocks.
    wait_edges(100);
    #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    #1 reset = 1'b0;

    pulse_at(200 + $urandom_range(0, 50));
    pulse_at(1000 + $urandom_range(0, 50));
    pulse_at(2000 + $urandom_range(0, 50));
    wait_edges(SP + 5 * HT);
    mode = 1;

    pulse_at(2 * FR + SP);
    pulse_at(2 * FR + SP + 1);
    wait_edges(2 * FR + SP + 5 * HT);
    mode = 2;

    pulse_at(3 * FR + $urandom_range(100, SP - 100));
    wait_edges(3 * FR + SP + 3 * HT);

    chk("swap_count", nswap, 3);
    chk("hsync_low_total", hs_tot, HS * VT);
    chk("vsync_low_total", vs_tot, VS * HT);
    chk("blank_total", bl_tot, FR - HA * VA);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
